// File: rtl/color_pkg.sv
// Shared constants for the colour serializer: code width, slots per word,
// slot-count width and the four colour code values.
package color_pkg;

    localparam int CW    = 2;
    localparam int N     = 4;
    localparam int CNT_W = 3;

    localparam logic [CW-1:0] COLOR_C0 = 2'd0;
    localparam logic [CW-1:0] COLOR_C1 = 2'd1;
    localparam logic [CW-1:0] COLOR_C2 = 2'd2;
    localparam logic [CW-1:0] COLOR_C3 = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter and full/empty flags; the head
// entry is presented combinationally on rdata.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: contents are only visible once counted in.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/color_serializer.sv
// Buffers packed colour words and emits one colour per clock, slot 0 first,
// reloading the shifter on its last colour so consecutive words run gap-free.
module color_serializer
    import color_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW*N-1:0]   in_word,
    input  logic [CNT_W-1:0]  in_cnt,
    output logic [CW-1:0]     color,
    output logic              color_valid,
    output logic              busy
);

    localparam int WW = CW * N;
    localparam int FW = WW + CNT_W;

    logic [FW-1:0]    head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             load;
    logic [WW-1:0]    word_p0;
    logic [CNT_W-1:0] rem_p0;
    logic [CW-1:0]    color_p1;
    logic             vld_p1;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(N)) ? CNT_W'(N) : c;
    endfunction

    assign in_ready    = !fifo_full;
    assign load        = (rem_p0 <= CNT_W'(1)) && !fifo_empty;
    assign color       = color_p1;
    assign color_valid = vld_p1;
    assign busy        = (rem_p0 != '0) | !fifo_empty | vld_p1;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (load),
        .wdata ({in_word, in_cnt}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stage p0 -> p1: shifter count and registered colour output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_p0   <= '0;
            color_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= (rem_p0 != '0);
            if (rem_p0 != '0) color_p1 <= word_p0[CW-1:0];
            if (load)
                rem_p0 <= sat_cnt(head[CNT_W-1:0]);
            else if (rem_p0 != '0)
                rem_p0 <= rem_p0 - CNT_W'(1);
        end
    end

    // Word bits are meaningless while rem_p0 is zero, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load)
            word_p0 <= head[FW-1:CNT_W];
        else if (rem_p0 != '0)
            word_p0 <= word_p0 >> CW;
    end

endmodule

// File: tb/tb_color_serializer.sv
// Directed bench for color_serializer with hand-derived per-cycle colour streams.
module tb_color_serializer;
    import color_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [CW*N-1:0]  in_word;
    logic [CNT_W-1:0] in_cnt;
    logic [CW-1:0]    color;
    logic             color_valid;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    color_serializer #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .in_cnt      (in_cnt),
        .color       (color),
        .color_valid (color_valid),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] w, input logic [2:0] c);
        in_valid = v;
        in_word  = w;
        in_cnt   = c;
    endtask

    // Entries are {color_valid, color}, one per cycle starting now.
    task automatic run_stream(input string tag);
        foreach (exp_q[i]) begin
            chk($sformatf("%s[%0d]", tag, i), {29'd0, color_valid, color}, {29'd0, exp_q[i]});
            step();
        end
        exp_q.delete();
    endtask

    logic [1:0] t3_exp [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0,
                                2'd2, 2'd2, 2'd1, 2'd1};

    initial begin
        reset = 1'b1;
        drive(1'b0, 8'h00, 3'd0);
        step();
        step();
        reset = 1'b0;

        // T1: idle after reset
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_vld", {31'd0, color_valid}, 32'd0);
            chk("t1_rdy", {31'd0, in_ready}, 32'd1);
            chk("t1_busy", {31'd0, busy}, 32'd0);
            chk("t1_color", {30'd0, color}, 32'd0);
        end

        // T2: single full word, 2-cycle latency
        drive(1'b1, 8'b11_10_01_00, 3'd4);
        step();
        drive(1'b0, 8'h00, 3'd0);
        chk("t2_busy_early", {31'd0, busy}, 32'd1);
        exp_q = '{3'b0_00, 3'b0_00, 3'b1_00, 3'b1_01, 3'b1_10, 3'b1_11, 3'b0_11};
        run_stream("t2");
        chk("t2_busy_end", {31'd0, busy}, 32'd0);

        // T3: three back-to-back words, back-pressure when two are buffered
        drive(1'b1, 8'b11_10_01_00, 3'd4);
        step();
        chk("t3_rdy_e1", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 8'b00_01_10_11, 3'd4);
        step();
        chk("t3_rdy_e2", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 8'b01_01_10_10, 3'd4);
        step();
        drive(1'b0, 8'h00, 3'd0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t3_col[%0d]", i), {29'd0, color_valid, color}, {29'd0, 1'b1, t3_exp[i]});
            if (i < 3)
                chk($sformatf("t3_rdy_full[%0d]", i), {31'd0, in_ready}, 32'd0);
            else if (i == 3)
                chk("t3_rdy_pop", {31'd0, in_ready}, 32'd1);
            step();
        end
        chk("t3_tail", {29'd0, color_valid, color}, {29'd0, 3'b0_01});
        chk("t3_busy_end", {31'd0, busy}, 32'd0);

        // T4: cnt=2, cnt=0, cnt=3 -> one bubble between
        drive(1'b1, 8'b00_00_11_01, 3'd2);
        step();
        drive(1'b1, 8'hFF, 3'd0);
        step();
        drive(1'b1, 8'b11_10_00_10, 3'd3);
        step();
        drive(1'b0, 8'h00, 3'd0);
        exp_q = '{3'b1_01, 3'b1_11, 3'b0_11, 3'b1_10, 3'b1_00, 3'b1_10, 3'b0_10};
        run_stream("t4");

        // cnt above N is clamped to N
        drive(1'b1, 8'b10_01_11_00, 3'd7);
        step();
        drive(1'b0, 8'h00, 3'd0);
        exp_q = '{3'b0_10, 3'b0_10, 3'b1_00, 3'b1_11, 3'b1_01, 3'b1_10, 3'b0_10};
        run_stream("t4_sat");

        // lone empty word: accepted, nothing emitted
        drive(1'b1, 8'hAA, 3'd0);
        step();
        drive(1'b0, 8'h00, 3'd0);
        chk("t4_empty_busy", {31'd0, busy}, 32'd1);
        step();
        exp_q = '{3'b0_10, 3'b0_10, 3'b0_10};
        run_stream("t4_empty");
        chk("t4_empty_idle", {31'd0, busy}, 32'd0);

        // T6: producer stall with empty FIFO, then a fresh word
        drive(1'b1, 8'b00_00_10_11, 3'd2);
        step();
        drive(1'b0, 8'h00, 3'd0);
        exp_q = '{3'b0_10, 3'b0_10, 3'b1_11, 3'b1_10, 3'b0_10, 3'b0_10, 3'b0_10};
        run_stream("t6_a");
        drive(1'b1, 8'b01_11_10_00, 3'd4);
        step();
        drive(1'b0, 8'h00, 3'd0);
        exp_q = '{3'b0_10, 3'b0_10, 3'b1_00, 3'b1_10, 3'b1_11, 3'b1_01, 3'b0_01};
        run_stream("t6_b");

        // T5: reset after second colour of a word
        drive(1'b1, 8'b11_10_01_00, 3'd4);
        step();
        drive(1'b1, 8'b11_11_11_11, 3'd4);
        step();
        drive(1'b0, 8'h00, 3'd0);
        step();
        chk("t5_c0", {29'd0, color_valid, color}, {29'd0, 3'b1_00});
        step();
        chk("t5_c1", {29'd0, color_valid, color}, {29'd0, 3'b1_01});
        reset = 1'b1;
        #1;
        chk("t5_rst_vld", {31'd0, color_valid}, 32'd0);
        chk("t5_rst_color", {30'd0, color}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_rdy", {31'd0, in_ready}, 32'd1);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t5_post_vld[%0d]", i), {31'd0, color_valid}, 32'd0);
            chk($sformatf("t5_post_busy[%0d]", i), {31'd0, busy}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
